mux_sel_arbiter: RTL and testbench

Round-robin select generator that sits directly upstream of the 4:1 mux and drives its 2-bit select `S`. Four requesters raise `req` bits. The block grants one requester at a time, holds the grant for a bounded number of cycles, and then rotates fairly. The mux routes input `I[S]` to `Y` for the duration of each grant. `gnt`/`busy` tell the sources whose data is currently on `Y`.

---
 rtl/mux_sel_arbiter.sv | 96 +++++++++
 tb/tb_mux_sel_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator driving a 4:1 mux select with bounded grants.
// Optional RR_LOCK_EN adds a lock input that holds the current grant.
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef RR_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] S,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n, s_n;
  logic [3:0]       gnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             found, take, locked;
  logic [1:0]       win, idx;

`ifdef RR_LOCK_EN
  assign locked = lock & req[S];
`else
  assign locked = 1'b0;
`endif

  // ptr itself is visited last so a sole requester is re-granted
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    s_n     = S;
    gnt_n   = gnt;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      IDLE: take = found;
      GRANT: begin
        if (!req[S] || (cnt == '0 && !locked)) begin
          take = found;
          if (!found) begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end
        end else if (!locked) begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
    endcase
    if (take) begin
      state_n = GRANT;
      gnt_n   = 4'b0001 << win;
      s_n     = win;
      ptr_n   = win;
      cnt_n   = CNT_W'(HOLD_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'b11;
      S     <= 2'b00;
      gnt   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      S     <= s_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      busy  <= |gnt_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed scoreboard bench for mux_sel_arbiter (default HOLD_CYCLES=4).
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
`ifdef RR_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [1:0] S;
  logic [3:0] gnt;
  logic       busy;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
`ifdef RR_LOCK_EN
    .lock (lock),
`endif
    .S    (S),
    .gnt  (gnt),
    .busy (busy)
  );

  task automatic push(input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    e.g = eg;
    e.s = es;
    e.b = |eg;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    total++;
    assert (gnt === e.g) else begin
      bad++;
      $error("FAIL %s gnt: got %b want %b", tag, gnt, e.g);
    end
    total++;
    assert (S === e.s) else begin
      bad++;
      $error("FAIL %s S: got %0d want %0d", tag, S, e.s);
    end
    total++;
    assert (busy === e.b) else begin
      bad++;
      $error("FAIL %s busy: got %b want %b", tag, busy, e.b);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] es);
    @(negedge clk);
    req = r;
    push(eg, es);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #2 rst = 1'b1;
    push(4'b0000, 2'd0);
    #1 check("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 5; r++) begin
      logic [1:0] ix;
      ix = 2'(r);
      for (int k = 0; k < 4; k++)
        step("rotate", 4'b1111, 4'b0001 << ix, ix);
    end

    step("wd_grant", 4'b0100, 4'b0100, 2'd2);
    step("wd_grant", 4'b0100, 4'b0100, 2'd2);
    step("wd_release", 4'b0000, 4'b0000, 2'd2);
    step("wd_idle", 4'b0000, 4'b0000, 2'd2);

    for (int k = 0; k < 8; k++)
      step("sole", 4'b0001, 4'b0001, 2'd0);
    step("sole_end", 4'b0000, 4'b0000, 2'd0);

    step("fair_g0", 4'b0001, 4'b0001, 2'd0);
    for (int k = 0; k < 3; k++)
      step("no_preempt", 4'b1011, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++)
      step("fair_g1", 4'b1011, 4'b0010, 2'd1);
    for (int k = 0; k < 4; k++)
      step("fair_g3", 4'b1011, 4'b1000, 2'd3);
    for (int k = 0; k < 4; k++)
      step("fair_g0b", 4'b1011, 4'b0001, 2'd0);
    step("fair_g1b", 4'b1011, 4'b0010, 2'd1);

    @(negedge clk);
    rst = 1'b1;
    push(4'b0000, 2'd0);
    #1 check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'b1111, 4'b0001, 2'd0);
    step("post_rst2", 4'b1111, 4'b0001, 2'd0);

`ifdef RR_LOCK_EN
    step("lk_idle", 4'b0000, 4'b0000, 2'd0);
    lock = 1'b1;
    for (int k = 0; k < 10; k++)
      step("locked", 4'b0110, 4'b0010, 2'd1);
    lock = 1'b0;
    for (int k = 0; k < 3; k++)
      step("unlock", 4'b0110, 4'b0010, 2'd1);
    step("lk_expire", 4'b0110, 4'b0100, 2'd2);
`endif

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain: left %0d want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
